imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, giving the instruction memory depth in 32-bit words (256 bytes).
REQ-002 SHALL have parameter ADDR_W, default 6, giving the word address width; log2(MEM_WORDS).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port word_count  input  7  number of words to load, sampled on start.
REQ-007 SHALL have port byte_in  input  8  incoming program byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in is valid.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 SHALL have port we  output  1  instruction memory write enable.
REQ-011 SHALL have port waddr  output  ADDR_W  instruction memory word address.
REQ-012 SHALL have port wdata  output  32  instruction word to write.
REQ-013 SHALL have port core_hold  output  1  holds the pipelined core stalled or in reset while loading.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the load completes.
REQ-015 SHALL have port err  output  1  checksum mismatch flag, sticky until the next start.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE and DONE, plus CHECK when LOADER_CHECKSUM_EN is defined.
REQ-017 IDLE: on start=1, SHALL latch the word count, clear word index and byte index, clear err, and go to RECV.
REQ-018 A word_count of 0 or greater than MEM_WORDS SHALL be treated as MEM_WORDS.
REQ-019 start in any state other than IDLE SHALL be ignored.
REQ-020 RECV: byte_ready SHALL be 1; a byte is accepted only when byte_valid=1 and byte_ready=1.
REQ-021 Accepted bytes SHALL be assembled little-endian: 1st byte to wdata[7:0], 4th byte to wdata[31:24].
REQ-022 On acceptance of the 4th byte, the FSM SHALL go to WRITE.
REQ-023 WRITE: SHALL last exactly one cycle, with we=1, waddr=word index, wdata=assembled word, and byte_ready=0.
REQ-024 Latency: we SHALL assert the cycle after the 4th byte is accepted.
REQ-025 After WRITE, the word index SHALL increment; if it was count-1, go to DONE (or CHECK when enabled), else go to RECV.
REQ-026 The word index SHALL never exceed MEM_WORDS-1; no wrap to 0 within one load.
REQ-027 byte_valid=0 in RECV SHALL stall the FSM indefinitely with no timeout; partial bytes are retained.
REQ-028 DONE: done=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-029 core_hold SHALL be 1 in every state except IDLE.
REQ-030 we SHALL be 0 in every state except WRITE.
REQ-031 byte_ready SHALL be 0 in every state except RECV.

Reset
REQ-032 rst=1 SHALL force IDLE and set we, byte_ready, core_hold, done, err, waddr and wdata to 0, and clear both indices.
REQ-033 rst SHALL take priority over start and over any byte handshake in the same cycle.
REQ-034 Reset mid-load SHALL NOT roll back words already written; no further writes occur until the next start.

Configuration
REQ-035 Macro LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-036 When defined: after the last WRITE, the FSM SHALL enter CHECK and receive 4 more bytes (little-endian) as the expected checksum, with byte_ready=1.
REQ-037 The checksum SHALL be the sum of all written words modulo 2^32.
REQ-038 In CHECK, no write SHALL occur; on mismatch err is set to 1 in the same cycle DONE is entered; done still pulses.
REQ-039 When undefined: the CHECK state and checksum accumulator SHALL be absent, the FSM goes WRITE to DONE, and err is tied to 0.

Verification
REQ-040 Scenario: rst, then start with word_count=2 and bytes 13 00 00 00 93 00 10 00 -> we pulses at waddr 0 with 00000013 and at waddr 1 with 00100093; done pulses once; core_hold returns to 0.
REQ-041 Scenario: byte_valid toggled 1/0 every cycle during a 1-word load -> exactly one we, correct word, byte_ready never 1 during WRITE.
REQ-042 Scenario: word_count=0 with 256 bytes of value k -> 64 writes, waddr 0..63, no write to waddr 0 after index 63.
REQ-043 Scenario: rst asserted after 2 bytes of word 1 -> outputs zero next cycle; a new start with 1 word writes waddr 0.
REQ-044 Scenario: start pulsed again mid-load -> ignored; the write count equals the original word_count.
REQ-045 Scenario: LOADER_CHECKSUM_EN defined, words 00000001 and 00000002, checksum bytes 03 00 00 00 -> err=0; checksum bytes 04 00 00 00 -> err=1; done pulses in both cases.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams bytes into 32-bit instruction words and writes them to
//               the instruction memory while holding the core. The optional
//               checksum stage is enabled by defining LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd4;
`endif
    localparam logic [31:0] c_mem_words = MEM_WORDS;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_bidx;
    logic [31:0]       r_word;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
    logic              r_err;
`endif

    logic              w_accept;
    logic [31:0]       w_word;
    logic [31:0]       w_cnt_ext;
    logic [ADDR_W-1:0] w_last;

    assign w_accept  = r_ready & byte_valid;
    assign w_cnt_ext = {25'd0, word_count};

    // Out-of-range counts (zero or larger than the memory) load the whole memory.
    assign w_last = (w_cnt_ext == 32'd0 || w_cnt_ext > c_mem_words)
                    ? ADDR_W'(c_mem_words - 32'd1)
                    : ADDR_W'(w_cnt_ext - 32'd1);

    always_comb begin
        w_word = r_word;
        case (r_bidx)
            2'd0:    w_word[7:0]   = byte_in;
            2'd1:    w_word[15:8]  = byte_in;
            2'd2:    w_word[23:16] = byte_in;
            default: w_word[31:24] = byte_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_word  <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last  <= w_last;
                        r_widx  <= '0;
                        r_bidx  <= '0;
                        r_word  <= '0;
                        r_ready <= 1'b1;
                        r_hold  <= 1'b1;
                        r_state <= S_RECV;
`ifdef LOADER_CHECKSUM_EN
                        r_sum   <= '0;
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_word <= w_word;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                            r_waddr <= r_widx;
                            r_wdata <= w_word;
                            r_state <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                            r_sum   <= r_sum + w_word;
`endif
                        end
                    end
                end
                S_WRITE: begin
                    // The index saturates on the last word so it never wraps to 0.
                    if (r_widx == r_last) begin
`ifdef LOADER_CHECKSUM_EN
                        r_ready <= 1'b1;
                        r_state <= S_CHECK;
`else
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_widx  <= r_widx + 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_RECV;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_word <= w_word;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= (w_word != r_sum);
                            r_state <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_hold  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_hold  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign core_hold  = r_hold;
    assign done       = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Randomised scoreboard bench for imem_loader; expected writes
//               are derived from the byte stream, not from the loader's states.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int MEM_WORDS = 64;
    localparam int ADDR_W    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [6:0]        word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_wr[$];
    int   exp_cyc[$];
    logic exp_err[$];
    wr_t  mon_e;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    imem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Monitor: every write and every done pulse is popped against the scoreboard.
    always @(negedge clk) begin
        if (we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                check("waddr", 32'(waddr), 32'(mon_e.addr));
                check("wdata", wdata, mon_e.data);
            end
            if (exp_cyc.size() == 0) check("write_latency_missing", 32'd1, 32'd0);
            else                     check("write_latency", 32'(cyc), 32'(exp_cyc.pop_front()));
            check("ready_during_write", 32'(byte_ready), 32'd0);
            check("hold_during_write", 32'(core_hold), 32'd1);
        end
        if (done) begin
            done_cnt++;
            if (exp_err.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else                     check("err_at_done", 32'(err), 32'(exp_err.pop_front()));
            check("hold_at_done", 32'(core_hold), 32'd1);
        end
    end

    // gap: 0 = always valid, 1 = valid toggles every cycle, 2 = random gaps.
    // abort_at >= 0 resets the DUT after that many bytes; restart_at pulses start mid-load.
    task automatic run_load(input int wc, input bq_t data, input int gap,
                            input int abort_at, input int restart_at, input bit bad_sum);
        int          n;
        int          nsend;
        int          target;
        int          t;
        bit          tog;
        bit          restarted;
        bit          hs;
        logic [31:0] sum;
        logic [31:0] word;
        bq_t         stream;
        wr_t         e;

        n   = (wc == 0 || wc > MEM_WORDS) ? MEM_WORDS : wc;
        sum = 32'd0;
        for (int w = 0; w < n; w++) begin
            word = {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]};
            sum  = sum + word;
            if (abort_at < 0 || w < abort_at / 4) begin
                e.addr = w;
                e.data = word;
                exp_wr.push_back(e);
            end
        end
        for (int i = 0; i < 4 * n; i++) stream.push_back(data[i]);
        nsend = 4 * n;
`ifdef LOADER_CHECKSUM_EN
        if (bad_sum) sum = sum + 32'd1;
        for (int b = 0; b < 4; b++) stream.push_back(8'(sum >> (8 * b)));
        nsend = nsend + 4;
        if (abort_at < 0) exp_err.push_back(bad_sum);
`else
        if (abort_at < 0) exp_err.push_back(1'b0);
`endif
        if (abort_at >= 0) nsend = abort_at;

        @(negedge clk);
        start      = 1'b1;
        word_count = 7'(wc);
        @(negedge clk);
        start      = 1'b0;
        word_count = 7'($urandom);
        target     = done_cnt + 1;
        tog        = 1'b0;
        restarted  = 1'b0;

        for (int i = 0; i < nsend; i++) begin
            hs = 1'b0;
            t  = 0;
            while (!hs) begin
                @(negedge clk);
                start = 1'b0;
                if (i == restart_at && !restarted) begin
                    start      = 1'b1;
                    word_count = 7'd3;
                    restarted  = 1'b1;
                end
                case (gap)
                    0:       byte_valid = 1'b1;
                    1:       begin tog = ~tog; byte_valid = tog; end
                    default: byte_valid = ($urandom_range(0, 2) != 0);
                endcase
                byte_in = byte_valid ? stream[i] : 8'($urandom);
                hs = byte_valid && byte_ready;
                if (hs && (i % 4) == 3 && i < 4 * n) exp_cyc.push_back(cyc + 1);
                t++;
                if (t > 60) begin
                    check("byte_accept_timeout", 32'd1, 32'd0);
                    finish_now();
                end
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_byte_ready", 32'(byte_ready), 32'd0);
            check("rst_we", 32'(we), 32'd0);
            check("rst_waddr", 32'(waddr), 32'd0);
            check("rst_wdata", wdata, 32'd0);
            check("rst_core_hold", 32'(core_hold), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("writes_before_rst", 32'(exp_wr.size()), 32'd0);
            rst = 1'b0;
            exp_cyc.delete();
        end else begin
            t = 0;
            while (done_cnt < target && t < 40) begin
                @(negedge clk);
                t++;
            end
            check("done_seen", 32'(done_cnt >= target), 32'd1);
            @(negedge clk);
            check("hold_released", 32'(core_hold), 32'd0);
            check("done_single", 32'(done), 32'd0);
            check("idle_ready", 32'(byte_ready), 32'd0);
            check("load_writes_left", 32'(exp_wr.size()), 32'd0);
        end
    endtask

    initial begin
        bq_t d;
        int  wc;
        rst        = 1'b1;
        start      = 1'b0;
        word_count = 7'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_byte_ready", 32'(byte_ready), 32'd0);
        check("reset_we", 32'(we), 32'd0);
        check("reset_waddr", 32'(waddr), 32'd0);
        check("reset_wdata", wdata, 32'd0);
        check("reset_core_hold", 32'(core_hold), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, d, 0, -1, -1, 1'b0);

        d = rand_bytes(4);
        run_load(1, d, 1, -1, -1, 1'b0);

        d = {};
        for (int k = 0; k < 256; k++) d.push_back(8'(k));
        run_load(0, d, 0, -1, -1, 1'b0);

        d = rand_bytes(256);
        run_load(100, d, 2, -1, -1, 1'b0);

        d = rand_bytes(8);
        run_load(2, d, 0, 6, -1, 1'b0);
        d = rand_bytes(4);
        run_load(1, d, 0, -1, -1, 1'b0);

        d = rand_bytes(16);
        run_load(4, d, 2, -1, 5, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        d = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_load(2, d, 0, -1, -1, 1'b0);
        run_load(2, d, 0, -1, -1, 1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            wc = $urandom_range(1, 8);
            d  = rand_bytes(4 * wc);
            run_load(wc, d, 2, -1, -1, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("leftover_writes", 32'(exp_wr.size()), 32'd0);
        check("leftover_dones", 32'(exp_err.size()), 32'd0);
        finish_now();
    end

endmodule
`default_nettype wire
